// File: rtl/targ_spawn_seq_pkg.sv
// Shared types for the target-prediction consumer: address and predictor
// request/response/feedback records plus the spawn sequencer state encoding.
package targ_spawn_seq_pkg;

    localparam int addr_w            = 32;
    localparam int max_targ_pred_cnt = 4;
    localparam int targ_idx_w        = $clog2(max_targ_pred_cnt);
    localparam int targ_cnt_w        = $clog2(max_targ_pred_cnt + 1);

    typedef logic [addr_w-1:0]     addr_t;
    typedef logic [targ_idx_w-1:0] targ_idx_t;
    typedef logic [targ_cnt_w-1:0] targ_cnt_t;

    typedef struct packed {
        logic  valid;
        addr_t base_pc;
    } targ_pred_req_t;

    typedef struct packed {
        addr_t [max_targ_pred_cnt-1:0] pred_pc;
        targ_cnt_t                     pred_cnt;
    } targ_pred_rsp_t;

    typedef struct packed {
        logic  valid;
        addr_t base_pc;
        addr_t targ_pc;
    } targ_pred_fb_t;

    localparam targ_pred_req_t targ_pred_req_rst = '0;
    localparam targ_pred_fb_t  targ_pred_fb_rst  = '0;

    typedef enum logic [1:0] {
        IDLE,
        SPAWN,
        WAIT_RES
    } targ_spawn_state_t;

endpackage

// File: rtl/targ_spawn_seq_if.sv
// Jump-accept, spawn and resolution handshakes of the spawn sequencer.
interface targ_spawn_seq_if;
    import targ_spawn_seq_pkg::*;

    logic      jmp_valid;
    addr_t     jmp_base_pc;
    logic      jmp_ready;
    logic      spawn_valid;
    addr_t     spawn_pc;
    targ_idx_t spawn_idx;
    logic      spawn_ready;
    logic      res_valid;
    addr_t     res_targ_pc;
    logic      res_hit;
    targ_idx_t res_hit_idx;
    logic      res_done;

    modport master (
        output jmp_valid, jmp_base_pc, spawn_ready, res_valid, res_targ_pc,
        input  jmp_ready, spawn_valid, spawn_pc, spawn_idx, res_hit, res_hit_idx, res_done
    );

    modport slave (
        input  jmp_valid, jmp_base_pc, spawn_ready, res_valid, res_targ_pc,
        output jmp_ready, spawn_valid, spawn_pc, spawn_idx, res_hit, res_hit_idx, res_done
    );

endinterface

// File: rtl/targ_spawn_seq_match.sv
// Priority compare of the resolved target against the latched candidates;
// only the first cnt slots take part and the lowest matching slot wins.
module targ_spawn_seq_match
    import targ_spawn_seq_pkg::*;
#(
    parameter int max_paths = max_targ_pred_cnt
) (
    input  addr_t [max_paths-1:0] cand,
    input  targ_cnt_t             cnt,
    input  addr_t                 targ_pc,
    output logic                  hit,
    output targ_idx_t             hit_idx
);

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        // Scan high to low so the last assignment is the lowest match.
        for (int i = max_paths - 1; i >= 0; i--) begin
            if ((targ_cnt_t'(i) < cnt) && (cand[i] == targ_pc)) begin
                hit     = 1'b1;
                hit_idx = targ_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/targ_spawn_seq.sv
// Requests candidate targets for an indirect jump, spawns them one per
// handshake, then scores the resolved target and feeds it back to the predictor.
module targ_spawn_seq
    import targ_spawn_seq_pkg::*;
#(
    parameter int max_paths  = max_targ_pred_cnt,
    parameter int stat_width = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    targ_spawn_seq_if.slave       bus,
    output targ_pred_req_t        targ_pred_req,
    input  targ_pred_rsp_t        targ_pred_rsp,
    output targ_pred_fb_t         targ_pred_fb,
    output logic [stat_width-1:0] hit_cnt,
    output logic [stat_width-1:0] miss_cnt
);

    targ_spawn_state_t     state_q, state_d;
    addr_t [max_paths-1:0] cand_q;
    targ_cnt_t             cnt_q;
    targ_idx_t             idx_q;
    addr_t                 base_q;
    logic                  res_done_q;
    logic                  res_hit_q;
    targ_idx_t             res_hit_idx_q;
    targ_pred_fb_t         fb_q;
    logic [stat_width-1:0] hit_cnt_q, miss_cnt_q;

    logic      jmp_acc, spawn_acc, spawn_last, res_acc;
    logic      match_hit;
    targ_idx_t match_idx;
    targ_cnt_t rsp_cnt;

    function automatic targ_cnt_t clamp_cnt(input targ_cnt_t c);
        return (c > targ_cnt_t'(max_paths)) ? targ_cnt_t'(max_paths) : c;
    endfunction

    function automatic logic [stat_width-1:0] sat_inc(input logic [stat_width-1:0] v);
        return (&v) ? v : v + stat_width'(1);
    endfunction

    assign rsp_cnt = clamp_cnt(targ_pred_rsp.pred_cnt);

    // A jump is refused during the res_done cycle and while reset or flush is active.
    assign bus.jmp_ready   = en && !rst && !flush && (state_q == IDLE) && !res_done_q;
    assign jmp_acc         = bus.jmp_ready && bus.jmp_valid;
    assign bus.spawn_valid = en && (state_q == SPAWN);
    assign bus.spawn_pc    = cand_q[idx_q];
    assign bus.spawn_idx   = idx_q;
    assign spawn_acc       = bus.spawn_valid && bus.spawn_ready;
    assign spawn_last      = (targ_cnt_t'(idx_q) + targ_cnt_t'(1)) == cnt_q;
    assign res_acc         = en && !flush && bus.res_valid && (state_q != IDLE);

    assign bus.res_done    = en && res_done_q;
    assign bus.res_hit     = res_hit_q;
    assign bus.res_hit_idx = res_hit_idx_q;
    assign hit_cnt         = hit_cnt_q;
    assign miss_cnt        = miss_cnt_q;

    always_comb begin
        targ_pred_req = targ_pred_req_rst;
        if (jmp_acc) begin
            targ_pred_req.valid   = 1'b1;
            targ_pred_req.base_pc = bus.jmp_base_pc;
        end
    end

    always_comb begin
        targ_pred_fb       = fb_q;
        targ_pred_fb.valid = fb_q.valid && en;
    end

    targ_spawn_seq_match #(
        .max_paths (max_paths)
    ) u_targ_match (
        .cand    (cand_q),
        .cnt     (cnt_q),
        .targ_pc (bus.res_targ_pc),
        .hit     (match_hit),
        .hit_idx (match_idx)
    );

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (jmp_acc) state_d = (rsp_cnt != '0) ? SPAWN : WAIT_RES;
                end
                SPAWN: begin
                    if (res_acc)                      state_d = IDLE;
                    else if (spawn_acc && spawn_last) state_d = WAIT_RES;
                end
                WAIT_RES: begin
                    if (res_acc) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q        <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            base_q        <= '0;
            res_done_q    <= 1'b0;
            res_hit_q     <= 1'b0;
            res_hit_idx_q <= '0;
            fb_q          <= targ_pred_fb_rst;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            // Resolution outputs are single-cycle pulses.
            res_done_q    <= res_acc;
            res_hit_q     <= res_acc && match_hit;
            res_hit_idx_q <= (res_acc && match_hit) ? match_idx : '0;
            fb_q          <= targ_pred_fb_rst;
            if (res_acc) begin
                fb_q <= '{valid: 1'b1, base_pc: base_q, targ_pc: bus.res_targ_pc};
                if (match_hit) hit_cnt_q  <= sat_inc(hit_cnt_q);
                else           miss_cnt_q <= sat_inc(miss_cnt_q);
            end
            if (jmp_acc) begin
                base_q <= bus.jmp_base_pc;
                cnt_q  <= rsp_cnt;
                idx_q  <= '0;
                for (int i = 0; i < max_paths; i++) cand_q[i] <= targ_pred_rsp.pred_pc[i];
            end else if (spawn_acc && !flush) begin
                idx_q <= idx_q + targ_idx_t'(1);
            end
        end
    end

endmodule
